// File: rtl/downsamp_pkg.sv
// Shared definitions for the multichannel boxcar downsampler:
// accumulator width rule and output register state encoding.
package downsamp_pkg;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Accumulator growth is bounded by the largest block, 2^max_log2_rate samples.
    function automatic int acc_w(input int data_width, input int max_log2_rate);
        return data_width + max_log2_rate;
    endfunction

endpackage

// File: rtl/downsamp_multich_if.sv
// Sample-in / result-out handshake bundle for downsamp_multich.
// The master side drives samples and out_ready; the slave side is the downsampler.
interface downsamp_multich_if
    import downsamp_pkg::*;
#(
    parameter int DATA_WIDTH    = 14,
    parameter int CHANNELS      = 2,
    parameter int MAX_LOG2_RATE = 6
) ();
    localparam int ACC_W = acc_w(DATA_WIDTH, MAX_LOG2_RATE);

    logic                           in_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CHANNELS*ACC_W-1:0]      out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/downsamp_acc_ch.sv
// One channel of the boxcar accumulator: sums samples over a block and
// forms the block result as a raw sum or a floor-rounded average.
module downsamp_acc_ch
    import downsamp_pkg::*;
#(
    parameter int DATA_WIDTH    = 14,
    parameter int MAX_LOG2_RATE = 6,
    parameter int RATE_W        = $clog2(MAX_LOG2_RATE+1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            accept,
    input  logic                            complete,
    input  logic                            mode,
    input  logic [RATE_W-1:0]               rate,
    input  logic [DATA_WIDTH-1:0]           sample,
    output logic [acc_w(DATA_WIDTH, MAX_LOG2_RATE)-1:0] result
);
    localparam int ACC_W = acc_w(DATA_WIDTH, MAX_LOG2_RATE);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] samp_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] avg;

    assign samp_ext = {{MAX_LOG2_RATE{sample[DATA_WIDTH-1]}}, sample};
    assign sum      = acc + samp_ext;
    // Arithmetic shift of a signed value rounds toward -inf.
    assign avg      = sum >>> rate;
    assign result   = mode ? avg : sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (accept)
            acc <= complete ? '0 : sum;
    end

endmodule

// File: rtl/downsamp_multich.sv
// Multichannel 2^N boxcar downsampler with runtime rate, sum/average mode,
// a one-deep valid/ready output register and a sticky overrun flag.
module downsamp_multich
    import downsamp_pkg::*;
#(
    parameter int DATA_WIDTH    = 14,
    parameter int CHANNELS      = 2,
    parameter int MAX_LOG2_RATE = 6,
    parameter int RATE_W        = $clog2(MAX_LOG2_RATE+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [RATE_W-1:0] log2_rate,
    input  logic              mode,
    input  logic              clr_overrun,
    output logic              overrun,
    downsamp_multich_if.slave bus
);
    localparam int ACC_W = acc_w(DATA_WIDTH, MAX_LOG2_RATE);
    localparam int CNT_W = MAX_LOG2_RATE;

    logic [RATE_W-1:0]               rate_q;
    logic [RATE_W-1:0]               rate_clamp;
    logic [RATE_W-1:0]               rate_eff;
    logic [CNT_W-1:0]                count;
    logic [CNT_W-1:0]                cnt_last;
    logic                            accept;
    logic                            complete;
    logic [CHANNELS-1:0][ACC_W-1:0]  result;
    logic [CHANNELS-1:0][ACC_W-1:0]  out_q;
    logic [0:0]                      state;

    assign accept     = bus.in_valid & ena;
    assign rate_clamp = (log2_rate > RATE_W'(MAX_LOG2_RATE)) ? RATE_W'(MAX_LOG2_RATE) : log2_rate;
    // The first sample of a block already runs at the rate it latches.
    assign rate_eff   = (count == '0) ? rate_clamp : rate_q;
    assign cnt_last   = ~({CNT_W{1'b1}} << rate_eff);
    assign complete   = accept && (count == cnt_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rate_q <= '0;
        end else if (accept) begin
            if (count == '0)
                rate_q <= rate_clamp;
            count <= complete ? '0 : count + CNT_W'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        downsamp_acc_ch #(
            .DATA_WIDTH    (DATA_WIDTH),
            .MAX_LOG2_RATE (MAX_LOG2_RATE),
            .RATE_W        (RATE_W)
        ) u_acc (
            .clk      (clk),
            .rst      (rst),
            .accept   (accept),
            .complete (complete),
            .mode     (mode),
            .rate     (rate_eff),
            .sample   (bus.in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .result   (result[c])
        );
    end

    // One-deep output slot: a full slot that is not being drained drops the new result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_EMPTY;
            out_q   <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (complete) begin
                        out_q <= result;
                        state <= ST_FULL;
                    end
                end
                default: begin
                    if (complete && bus.out_ready)
                        out_q <= result;
                    else if (!complete && bus.out_ready)
                        state <= ST_EMPTY;
                end
            endcase

            if (state == ST_FULL && complete && !bus.out_ready)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

    assign bus.out_valid = (state == ST_FULL);
    assign bus.out_data  = out_q;

endmodule
